// File: rtl/rect_print_pkg.sv
// Shared types and constants for the rectangle print engine and its clip helper.
package rect_print_pkg;

   localparam int X_W       = 10;   // column coordinate / width
   localparam int Y_W       = 9;    // row coordinate / height
   localparam int CLIP_W    = 11;   // clip arithmetic width, wide enough that nothing wraps
   localparam int DEF_H_RES = 640;
   localparam int DEF_V_RES = 480;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/rect_clip.sv
// Combinational clip of a rectangle against the screen. The result is the visible
// width/height and an empty flag. It is shared with the sprite blitter.
module rect_clip
   import rect_print_pkg::*;
#(
   parameter int H_RES = DEF_H_RES,
   parameter int V_RES = DEF_V_RES
) (
   input  logic [X_W-1:0] i_x,
   input  logic [Y_W-1:0] i_y,
   input  logic [X_W-1:0] i_w,
   input  logic [Y_W-1:0] i_h,
   output logic [X_W-1:0] o_w_eff,
   output logic [Y_W-1:0] o_h_eff,
   output logic           o_empty
);

   logic [CLIP_W-1:0] w_x, w_y, w_wid, w_hgt;
   logic [CLIP_W-1:0] w_h_res, w_v_res;
   logic [CLIP_W-1:0] w_wid_room, w_hgt_room;
   logic [CLIP_W-1:0] w_wid_min, w_hgt_min;

   assign w_x     = CLIP_W'(i_x);
   assign w_y     = CLIP_W'(i_y);
   assign w_wid   = CLIP_W'(i_w);
   assign w_hgt   = CLIP_W'(i_h);
   assign w_h_res = CLIP_W'(H_RES);
   assign w_v_res = CLIP_W'(V_RES);

   // Off-screen origin or a zero dimension leaves nothing to draw.
   assign o_empty = (w_x >= w_h_res) | (w_y >= w_v_res) | (i_w == '0) | (i_h == '0);

   // The room terms can wrap only when o_empty is set, and then the results are forced to zero.
   assign w_wid_room = w_h_res - w_x;
   assign w_hgt_room = w_v_res - w_y;
   assign w_wid_min  = (w_wid < w_wid_room) ? w_wid : w_wid_room;
   assign w_hgt_min  = (w_hgt < w_hgt_room) ? w_hgt : w_hgt_room;

   assign o_w_eff = o_empty ? '0 : X_W'(w_wid_min);
   assign o_h_eff = o_empty ? '0 : Y_W'(w_hgt_min);

endmodule

// File: rtl/rect_print_engine.sv
// Solid-colour rectangle fill into the VGA framebuffer. Commands arrive on a
// valid/ready handshake. Pixels go out row-major as Avalon-MM writes.
// printing feeds the software-visible status PIO.
module rect_print_engine
   import rect_print_pkg::*;
#(
   parameter int H_RES     = DEF_H_RES,
   parameter int V_RES     = DEF_V_RES,
   parameter int ADDR_W    = 19,
   parameter int COLOR_W   = 8,
   parameter int BASE_ADDR = 0
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [X_W-1:0]     cmd_x,
   input  logic [Y_W-1:0]     cmd_y,
   input  logic [X_W-1:0]     cmd_w,
   input  logic [Y_W-1:0]     cmd_h,
   input  logic [COLOR_W-1:0] cmd_color,
   output logic [ADDR_W-1:0]  mem_address,
   output logic               mem_write,
   output logic [COLOR_W-1:0] mem_writedata,
   input  logic               mem_waitrequest,
   output logic               printing,
   output logic               done
);

   state_t r_state, w_next_state;

   logic [X_W-1:0]     r_x, r_w, r_w_eff, r_col;
   logic [Y_W-1:0]     r_y, r_h, r_h_eff, r_row;
   logic [COLOR_W-1:0] r_color;
   logic [ADDR_W-1:0]  r_addr, r_row_base;

   logic [X_W-1:0]     w_w_eff;
   logic [Y_W-1:0]     w_h_eff;
   logic               w_empty;
   logic               w_accept, w_beat, w_last_col, w_last_row;
   logic [ADDR_W-1:0]  w_start_addr, w_next_row_base;

   rect_clip #(
      .H_RES (H_RES),
      .V_RES (V_RES)
   ) u_clip (
      .i_x     (r_x),
      .i_y     (r_y),
      .i_w     (r_w),
      .i_h     (r_h),
      .o_w_eff (w_w_eff),
      .o_h_eff (w_h_eff),
      .o_empty (w_empty)
   );

   assign w_accept   = cmd_valid & cmd_ready;
   assign w_beat     = (r_state == ST_WRITE) & ~mem_waitrequest;
   assign w_last_col = (r_col == r_w_eff - X_W'(1));
   assign w_last_row = (r_row == r_h_eff - Y_W'(1));

   // The only multiply in the design. It is used once per command, in SETUP. Later rows step by H_RES.
   assign w_start_addr    = ADDR_W'(BASE_ADDR) + ADDR_W'(r_y) * ADDR_W'(H_RES) + ADDR_W'(r_x);
   assign w_next_row_base = r_row_base + ADDR_W'(H_RES);

   // State register. Reset drops straight to IDLE, which kills mem_write at once.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
      end else begin
         // NOTE: non-blocking so every register samples pre-edge values regardless of block order.
         r_state <= w_next_state;
      end
   end

   // Next-state decode.
   always_comb begin
      // NOTE: default first so every path assigns w_next_state; otherwise a latch is inferred.
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:  if (w_accept) w_next_state = ST_SETUP;
         ST_SETUP: w_next_state = w_empty ? ST_DONE : ST_WRITE;
         ST_WRITE: if (w_beat && w_last_col && w_last_row) w_next_state = ST_DONE;
         ST_DONE:  w_next_state = ST_IDLE;
         default:  w_next_state = ST_IDLE;
      endcase
   end

   // Outputs decode from the state register only, so they stay stable through a stall.
   always_comb begin
      cmd_ready     = (r_state == ST_IDLE);
      printing      = (r_state != ST_IDLE);
      done          = (r_state == ST_DONE);
      mem_write     = (r_state == ST_WRITE);
      mem_address   = '0;
      mem_writedata = '0;
      if (r_state == ST_WRITE) begin
         mem_address   = r_addr;
         mem_writedata = r_color;
      end
   end

   // Command capture, clip/start-address setup and the row-major address walk.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_x        <= '0;
         r_y        <= '0;
         r_w        <= '0;
         r_h        <= '0;
         r_color    <= '0;
         r_w_eff    <= '0;
         r_h_eff    <= '0;
         r_col      <= '0;
         r_row      <= '0;
         r_addr     <= '0;
         r_row_base <= '0;
      end else begin
         if (w_accept) begin
            r_x     <= cmd_x;
            r_y     <= cmd_y;
            r_w     <= cmd_w;
            r_h     <= cmd_h;
            r_color <= cmd_color;
         end
         if (r_state == ST_SETUP) begin
            r_w_eff    <= w_w_eff;
            r_h_eff    <= w_h_eff;
            r_col      <= '0;
            r_row      <= '0;
            r_addr     <= w_start_addr;
            r_row_base <= w_start_addr;
         end else if (w_beat) begin
            if (!w_last_col) begin
               r_col  <= r_col + X_W'(1);
               r_addr <= r_addr + ADDR_W'(1);
            end else if (!w_last_row) begin
               r_col      <= '0;
               r_row      <= r_row + Y_W'(1);
               r_row_base <= w_next_row_base;
               r_addr     <= w_next_row_base;
            end
         end
      end
   end

endmodule
